click_tone_generator: RTL and testbench

- Downstream consumer of the metronome's single-cycle beat trigger.
- Converts each trigger into a fixed-length square-wave tone burst (a "click") on a buzzer/speaker pin.
- Tracks the beat position within a bar; the first beat of each bar is accented with a higher pitch.
- Sits between the metronome core and the board audio output pin.

---
 rtl/click_tone_generator.sv | 148 ++++++++++++++
 tb/tb_click_tone_generator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/click_tone_generator.sv
// Turns each accepted beat trigger into a fixed-length square-wave click; the first beat of a bar is pitched higher.
// Optional macro CLICK_ACCENT_EN enables beat tracking and accent pitch; without it every click uses NORMAL_HALF.
module click_tone_generator #(
  parameter int CLK_HZ      = 50000000,
  parameter int CLICK_MS    = 30,
  parameter int NORMAL_HALF = 25000,
  parameter int ACCENT_HALF = 12500,
  parameter int BPB_W       = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_trigger,
  input  logic             i_enable,
  input  logic             i_bar_reset,
  input  logic [BPB_W-1:0] i_beats_per_bar,
  output logic             o_tone,
  output logic             o_busy,
  output logic             o_accent,
  output logic [BPB_W-1:0] o_beat_index
);

  localparam int CLICK_CYCLES = (CLK_HZ / 1000) * CLICK_MS;
  localparam int MAX_HALF     = (NORMAL_HALF > ACCENT_HALF) ? NORMAL_HALF : ACCENT_HALF;
  localparam int MAX_CNT      = (CLICK_CYCLES > MAX_HALF) ? CLICK_CYCLES : MAX_HALF;
  localparam int CNT_W        = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] half_len_q, half_len_d;
  logic             tone_q, tone_d;
  logic             accent_q, accent_d;
  logic             accept;
  logic             accent_now;
  logic [CNT_W-1:0] half_sel;

  assign accept = i_trigger & i_enable;

`ifdef CLICK_ACCENT_EN
  logic [BPB_W-1:0] next_idx_q, next_idx_d;
  logic [BPB_W-1:0] beat_index_q, beat_index_d;
  logic [BPB_W-1:0] pos;
  logic             bpb_le1;

  // A shrunk bar length that leaves next_idx out of range restarts the count at 0.
  always_comb begin
    bpb_le1      = (i_beats_per_bar <= BPB_W'(1));
    pos          = next_idx_q;
    next_idx_d   = next_idx_q;
    beat_index_d = beat_index_q;
    if (i_bar_reset || bpb_le1 || (next_idx_q >= i_beats_per_bar)) pos = '0;
    if (accept) begin
      beat_index_d = pos;
      if (bpb_le1 || (pos == i_beats_per_bar - BPB_W'(1))) next_idx_d = '0;
      else                                                 next_idx_d = pos + BPB_W'(1);
    end else if (i_bar_reset) begin
      next_idx_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      next_idx_q   <= '0;
      beat_index_q <= '0;
    end else begin
      next_idx_q   <= next_idx_d;
      beat_index_q <= beat_index_d;
    end
  end

  assign accent_now   = (pos == '0);
  assign o_beat_index = beat_index_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{i_bar_reset, i_beats_per_bar};
  assign accent_now    = 1'b0;
  assign o_beat_index  = '0;
`endif

  assign half_sel = accent_now ? CNT_W'(ACCENT_HALF) : CNT_W'(NORMAL_HALF);

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    half_d     = half_q;
    half_len_d = half_len_q;
    tone_d     = tone_q;
    accent_d   = accent_q;
    if (!i_enable) begin
      state_d  = S_IDLE;
      dur_d    = '0;
      half_d   = '0;
      tone_d   = 1'b0;
      accent_d = 1'b0;
    end else if (i_trigger) begin
      // A retrigger restarts the burst with freshly latched pitch.
      state_d    = S_TONE;
      dur_d      = CNT_W'(CLICK_CYCLES - 1);
      half_d     = half_sel - CNT_W'(1);
      half_len_d = half_sel - CNT_W'(1);
      tone_d     = 1'b1;
      accent_d   = accent_now;
    end else if (state_q == S_TONE) begin
      if (dur_q == '0) begin
        state_d  = S_IDLE;
        half_d   = '0;
        tone_d   = 1'b0;
        accent_d = 1'b0;
      end else begin
        dur_d = dur_q - CNT_W'(1);
        if (half_q == '0) begin
          half_d = half_len_q;
          tone_d = ~tone_q;
        end else begin
          half_d = half_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      dur_q      <= '0;
      half_q     <= '0;
      half_len_q <= '0;
      tone_q     <= 1'b0;
      accent_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      half_q     <= half_d;
      half_len_q <= half_len_d;
      tone_q     <= tone_d;
      accent_q   <= accent_d;
    end
  end

  assign o_tone   = tone_q;
  assign o_busy   = (state_q == S_TONE);
  assign o_accent = accent_q;

endmodule

// File: tb/tb_click_tone_generator.sv
// Self-checking bench for click_tone_generator: directed scenarios then random stimulus against a burst-level model.
module tb_click_tone_generator;

  localparam int BPB_W = 4;
  localparam int CLICK = 100;
  localparam int NHALF = 10;
  localparam int AHALF = 5;
`ifdef CLICK_ACCENT_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             trig = 1'b0;
  logic             en = 1'b0;
  logic             bar = 1'b0;
  logic [BPB_W-1:0] bpb = 4'd4;
  logic             tone, busy, accent;
  logic [BPB_W-1:0] beat_index;

  int errors = 0;
  int checks = 0;

  // Burst-level model: time since burst start, burst pitch, bar position.
  bit m_act = 0;
  bit m_acc = 0;
  int m_k = 0;
  int m_half = NHALF;
  int m_index = 0;
  int m_count = 0;

  click_tone_generator #(
    .CLK_HZ(100000), .CLICK_MS(1), .NORMAL_HALF(NHALF), .ACCENT_HALF(AHALF), .BPB_W(BPB_W)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_trigger(trig), .i_enable(en),
    .i_bar_reset(bar), .i_beats_per_bar(bpb),
    .o_tone(tone), .o_busy(busy), .o_accent(accent), .o_beat_index(beat_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BPB_W-1:0] obs, input logic [BPB_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_tone;
    exp_tone = m_act && (((m_k / m_half) % 2) == 0);
    chk("busy",   {3'b0, busy},   {3'b0, m_act});
    chk("tone",   {3'b0, tone},   {3'b0, exp_tone});
    chk("accent", {3'b0, accent}, {3'b0, (m_act && m_acc)});
    chk("index",  beat_index,     BPB_W'(m_index));
  endtask

  task automatic model_reset();
    m_act = 0; m_acc = 0; m_k = 0; m_index = 0; m_count = 0; m_half = NHALF;
  endtask

  task automatic model_edge(input logic t, input logic e, input logic b);
    int n;
    int pos;
    n = int'(bpb);
    if (!e) begin
      m_act = 0;
    end else if (t) begin
      m_acc = 0;
      if (ACC) begin
        pos = (n <= 1 || b || m_count >= n) ? 0 : m_count;
        m_index = pos;
        m_acc = (pos == 0);
        m_count = (n <= 1) ? 0 : (pos + 1) % n;
      end
      m_act = 1;
      m_k = 0;
      m_half = m_acc ? AHALF : NHALF;
    end else if (m_act) begin
      m_k++;
      if (m_k >= CLICK) m_act = 0;
    end
    if (ACC && b && !(t && e)) m_count = 0;
  endtask

  task automatic step(input logic t, input logic e, input logic b);
    @(negedge clk);
    trig = t; en = e; bar = b;
    @(posedge clk);
    model_edge(t, e, b);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    idle(3);

    // Single accented click
    step(1, 1, 0); idle(110);

    // Five triggers 200 cycles apart, starting from a fresh bar
    step(0, 1, 1);
    for (int i = 0; i < 5; i++) begin step(1, 1, 0); idle(199); end

    // Retrigger halfway through a burst
    step(1, 1, 0); idle(49); step(1, 1, 0); idle(110);

    // Bar reset coincident with the third trigger
    step(0, 1, 1);
    step(1, 1, 0); idle(150);
    step(1, 1, 0); idle(150);
    step(1, 1, 1); idle(150);
    step(1, 1, 0); idle(150);

    // Enable dropped mid-burst, trigger while disabled
    step(1, 1, 0); idle(30);
    step(0, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    idle(3);
    step(1, 1, 0); idle(110);

    // Asynchronous reset mid-burst
    step(1, 1, 0); idle(20);
    @(negedge clk);
    rst_n = 1'b0; trig = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    step(1, 1, 0); idle(110);

    // Degenerate bar lengths and shrinking the bar below the current position
    bpb = 4'd1; step(1, 1, 0); idle(40); step(1, 1, 0); idle(105);
    bpb = 4'd0; step(1, 1, 0); idle(105);
    bpb = 4'd4; step(0, 1, 1);
    for (int i = 0; i < 3; i++) begin step(1, 1, 0); idle(30); end
    bpb = 4'd2; step(1, 1, 0); idle(30); step(1, 1, 0); idle(30); step(1, 1, 0); idle(105);

    // Random traffic
    bpb = 4'd4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) bpb = BPB_W'($urandom_range(0, 6));
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 149) != 0), ($urandom_range(0, 79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
